// File: rtl/mmio_bridge.sv
// Bridge from a core load/store port onto a memory-mapped output window.
// Each accepted request is checked, issued for one cycle, then answered until the core takes it.
module mmio_bridge #(
    parameter logic [31:0] OUTPUT_BASE = 32'hFFFF_0000,
    parameter logic [31:0] OUTPUT_SPAN = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] output_address,
    output logic [31:0] output_in,
    output logic [1:0]  output_size,
    output logic        output_write_enable,
    input  logic [31:0] output_out,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state;
    state_t      next_state;
    logic        cap_write;
    logic        accept;
    logic        in_window;
    logic        misaligned;
    logic        req_error;
    logic [32:0] win_lo;
    logic [32:0] win_hi;

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    assign accept = req_valid && req_ready;

    // Window bounds are computed 33 bits wide so a window touching the top of memory cannot wrap.
    always_comb begin
        win_lo    = {1'b0, OUTPUT_BASE};
        win_hi    = win_lo + {1'b0, OUTPUT_SPAN};
        in_window = ({1'b0, req_addr} >= win_lo) && ({1'b0, req_addr} < win_hi);
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
        req_error = !in_window || misaligned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = req_error ? RESP : ISSUE;
            ISSUE:   next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready           = (state == IDLE);
        rsp_valid           = (state == RESP);
        output_write_enable = (state == ISSUE) && cap_write;
    end

    // Load data is taken from the output map on the edge that leaves ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_write      <= 1'b0;
            output_address <= '0;
            output_in      <= '0;
            output_size    <= '0;
            rsp_rdata      <= '0;
            rsp_error      <= 1'b0;
            err_count      <= '0;
        end else if (accept) begin
            cap_write      <= req_write;
            output_address <= req_addr - OUTPUT_BASE;
            output_in      <= req_wdata & size_mask(req_size);
            output_size    <= req_size;
            rsp_rdata      <= '0;
            rsp_error      <= req_error;
            if (req_error && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end else if (state == ISSUE) begin
            rsp_rdata <= cap_write ? 32'h0
                       : ((output_out >> {output_address[1:0], 3'b000}) & size_mask(output_size));
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed cases plus randomized requests
// compared against an address/size level reference model.
module tb_mmio_bridge;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] SPAN = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] output_address;
    logic [31:0] output_in;
    logic [1:0]  output_size;
    logic        output_write_enable;
    logic [31:0] output_out = '0;
    logic [15:0] err_count;

    int checks = 0;
    int failures = 0;
    int model_err = 0;

    mmio_bridge #(.OUTPUT_BASE(BASE), .OUTPUT_SPAN(SPAN)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_size            (req_size),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_rdata           (rsp_rdata),
        .rsp_error           (rsp_error),
        .output_address      (output_address),
        .output_in           (output_in),
        .output_size         (output_size),
        .output_write_enable (output_write_enable),
        .output_out          (output_out),
        .err_count           (err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference rules: inside [BASE, BASE+SPAN), legal size, naturally aligned.
    function automatic bit refError(input logic [31:0] addr, input logic [1:0] size);
        longint a  = longint'(addr);
        longint lo = longint'(BASE);
        longint hi = longint'(BASE) + longint'(SPAN);
        if (a < lo || a >= hi) return 1'b1;
        if (size == 2'd3) return 1'b1;
        return (a % (longint'(1) << size)) != 0;
    endfunction

    function automatic logic [31:0] refMask(input logic [1:0] size);
        longint nbytes = longint'(1) << size;
        return 32'((longint'(1) << (8 * nbytes)) - 1);
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] out_val, input logic [31:0] addr,
                                            input logic [1:0] size);
        int lane = int'((addr - BASE) % 4);
        return (out_val >> (8 * lane)) & refMask(size);
    endfunction

    task automatic applyStimulus(input bit write, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size);
        req_valid = 1'b1;
        req_write = write;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
    endtask

    // One full transaction: accept, check strobe/response timing, hold the response, retire it.
    task automatic runTxn(input string tag, input bit write, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size,
                          input logic [31:0] out_val, input int hold);
        bit          err = refError(addr, size);
        logic [31:0] exp_rdata;
        checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        applyStimulus(write, addr, wdata, size);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (err) begin
            if (model_err < 65535) model_err++;
            exp_rdata = 32'h0;
            checkOutput({tag, ".err_rsp_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, ".err_rsp_error"}, 32'(rsp_error), 32'd1);
            checkOutput({tag, ".err_strobe"}, 32'(output_write_enable), 32'd0);
        end else begin
            exp_rdata = write ? 32'h0 : refLoad(out_val, addr, size);
            checkOutput({tag, ".strobe"}, 32'(output_write_enable), 32'(write));
            checkOutput({tag, ".out_addr"}, output_address, addr - BASE);
            checkOutput({tag, ".out_in"}, output_in, wdata & refMask(size));
            checkOutput({tag, ".out_size"}, 32'(output_size), 32'(size));
            checkOutput({tag, ".early_rsp"}, 32'(rsp_valid), 32'd0);
            output_out = out_val;
            @(posedge clk); #1;
            output_out = $urandom;
            checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, ".rsp_error"}, 32'(rsp_error), 32'd0);
            checkOutput({tag, ".strobe_off"}, 32'(output_write_enable), 32'd0);
        end
        checkOutput({tag, ".rdata"}, rsp_rdata, exp_rdata);
        for (int i = 0; i < hold; i++) begin
            applyStimulus($urandom_range(0, 1), BASE + 32'($urandom_range(0, 255)), $urandom, 2'd0);
            @(posedge clk); #1;
            checkOutput({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, ".hold_rdata"}, rsp_rdata, exp_rdata);
            checkOutput({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput({tag, ".retired"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, ".err_count"}, 32'(err_count), 32'(model_err));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, ".rsp_error"}, 32'(rsp_error), 32'd0);
        checkOutput({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
        checkOutput({tag, ".out_addr"}, output_address, 32'd0);
        checkOutput({tag, ".out_in"}, output_in, 32'd0);
        checkOutput({tag, ".out_size"}, 32'(output_size), 32'd0);
        checkOutput({tag, ".strobe"}, 32'(output_write_enable), 32'd0);
        checkOutput({tag, ".err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        logic [31:0] addr;
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        runTxn("byte_store", 1'b1, 32'hFFFF_0000, 32'h0000_12A5, 2'd0, 32'h0, 0);
        runTxn("word_load", 1'b0, 32'hFFFF_0000, 32'h0, 2'd2, 32'h0000_00A5, 0);
        runTxn("byte_load_off1", 1'b0, 32'hFFFF_0001, 32'h0, 2'd0, 32'h0000_00A5, 0);
        runTxn("store_past_end", 1'b1, 32'hFFFF_0100, 32'h1234_5678, 2'd0, 32'h0, 0);
        runTxn("word_misalign", 1'b1, 32'hFFFF_0002, 32'h1234_5678, 2'd2, 32'h0, 0);
        checkOutput("err_after_two", 32'(err_count), 32'd2);
        runTxn("hold_load", 1'b0, 32'hFFFF_0042, 32'h0, 2'd1, 32'hBEEF_CAFE, 5);
        runTxn("below_base", 1'b0, 32'hFFFE_FFFF, 32'h0, 2'd0, 32'h0, 1);
        runTxn("last_byte", 1'b0, 32'hFFFF_00FF, 32'h0, 2'd0, 32'h8877_6655, 0);
        runTxn("reserved_size", 1'b0, 32'hFFFF_0010, 32'h0, 2'd3, 32'h0, 0);
        runTxn("half_odd", 1'b0, 32'hFFFF_0011, 32'h0, 2'd1, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       addr = BASE + 32'($urandom_range(0, 255));
                1:       addr = BASE + 32'($urandom_range(248, 264));
                2:       addr = BASE - 32'($urandom_range(1, 8));
                default: addr = $urandom;
            endcase
            runTxn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), addr, $urandom,
                   2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 2));
        end

        // Reset in the middle of a store's issue cycle.
        applyStimulus(1'b1, BASE + 32'd4, 32'hCAFE_F00D, 2'd2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rst_pre_strobe", 32'(output_write_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_err = 0;
        checkResetValues("rst_mid_issue");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("rst_no_rsp", 32'(rsp_valid), 32'd0);
            checkOutput("rst_no_strobe", 32'(output_write_enable), 32'd0);
        end

        // First edge after deassertion must accept.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("rst_again");
        #2 rst_n = 1'b1;
        runTxn("first_after_rst", 1'b1, BASE + 32'h20, 32'h0000_ABCD, 2'd1, 32'h0, 0);

        // Pre-load the counter near its limit, then drive it into saturation.
        force dut.err_count = 16'hFFFB;
        #1 release dut.err_count;
        model_err = 65531;
        for (int i = 0; i < 7; i++) begin
            runTxn($sformatf("sat%0d", i), 1'b1, BASE + SPAN + 32'(i), 32'h0, 2'd0, 32'h0, 0);
        end
        checkOutput("sat_final", 32'(err_count), 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameter OUTPUT_BASE, default 32'hFFFF_0000, SHALL set the byte base address of the output-map window.
REQ-002 Parameter OUTPUT_SPAN, default 32'h0000_0100, SHALL set the window size in bytes; the window is [OUTPUT_BASE, OUTPUT_BASE+OUTPUT_SPAN).
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  in  1  SHALL mean the core presents a load/store request.
REQ-006 req_ready  out  1  SHALL mean the bridge accepts a request this cycle.
REQ-007 req_write  in  1  SHALL select store (1) or load (0).
REQ-008 req_addr  in  32  SHALL be the byte address.
REQ-009 req_wdata  in  32  SHALL be store data, right-aligned.
REQ-010 req_size  in  2  SHALL be the access size: 0 byte, 1 half, 2 word, 3 reserved.
REQ-011 rsp_valid  out  1  SHALL mean a response is presented.
REQ-012 rsp_ready  in  1  SHALL mean the core takes the response this cycle.
REQ-013 rsp_rdata  out  32  SHALL carry load data, zero-extended; 0 for stores and errors.
REQ-014 rsp_error  out  1  SHALL flag an out-of-window, misaligned or reserved-size access.
REQ-015 output_address  out  32  SHALL be the window-relative offset (req_addr - OUTPUT_BASE).
REQ-016 output_in  out  32  SHALL be the store data masked to the access size, upper bits 0.
REQ-017 output_size  out  2  SHALL be the captured req_size.
REQ-018 output_write_enable  out  1  SHALL be the single-cycle store strobe to the output map.
REQ-019 output_out  in  32  SHALL be the output map's read data.
REQ-020 err_count  out  16  SHALL count errored requests, saturating at 16'hFFFF.

Function
REQ-021 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, and all req_* fields are captured.
REQ-023 On accept, the request is errored if the address is outside the window, or size=3, or half with addr[0]=1, or word with addr[1:0]!=0; the window check uses 33-bit arithmetic with no wrap.
REQ-024 An errored request SHALL go IDLE->RESP: rsp_error=1, rsp_rdata=0, no output strobe, err_count+1 (saturating).
REQ-025 A valid request SHALL go IDLE->ISSUE->RESP; ISSUE lasts exactly one cycle.
REQ-026 In ISSUE, output_address, output_in and output_size SHALL hold the captured values, and output_write_enable SHALL be 1 iff the request is a store.
REQ-027 output_write_enable SHALL be 0 in every state other than ISSUE.
REQ-028 For loads, output_out SHALL be sampled at the end of ISSUE, shifted right by 8*offset[1:0], masked to the size, and registered into rsp_rdata.
REQ-029 Latency: a request accepted at edge N SHALL produce its strobe in cycle N+1 and rsp_valid from N+2 (valid path), or rsp_valid from N+1 (error path).
REQ-030 In RESP, rsp_valid=1 and rsp_rdata/rsp_error SHALL stay stable until rsp_ready=1; the FSM then returns to IDLE on that edge.
REQ-031 Back-to-back throughput SHALL be at most one request per 3 cycles (valid path) or per 2 cycles (error path); no request is accepted while rsp_valid=1.
REQ-032 The output_* outputs SHALL hold their last captured values outside ISSUE; only the strobe qualifies them.

Reset
REQ-033 On rst_n=0, the block SHALL immediately enter IDLE with: req_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, output_address=0, output_in=0, output_size=0, output_write_enable=0, err_count=0.
REQ-034 Reset asserted during ISSUE or RESP SHALL drop the pending transaction: no strobe completes and no response is delivered after release.
REQ-035 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-036 Byte store, addr=FFFF_0000, wdata=0000_12A5, size=0 -> one-cycle strobe at N+1 with output_address=0, output_in=0000_00A5; response rsp_error=0, rsp_rdata=0.
REQ-037 Word load, addr=FFFF_0000, output_out=0000_00A5 -> rsp_valid at N+2 with rsp_rdata=0000_00A5; byte load at FFFF_0001 -> rsp_rdata=0000_0000.
REQ-038 Store to FFFF_0100, then word store to FFFF_0002 -> both return rsp_error=1 at N+1, no strobe, err_count=2.
REQ-039 rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable throughout, req_ready=0; a new req_valid is not accepted until rsp_ready is asserted.
REQ-040 rst_n pulsed low during ISSUE of a store -> strobe deasserts immediately, all outputs return to reset values, and no response follows.
REQ-041 65 540 errored requests -> err_count saturates at FFFF and does not wrap.
